// File: rtl/comm_unit_pkg.sv
// Shared types and constants for the communication unit: control-word
// layout, opcode encodings and FSM state encoding.
package COMM_PKG;

    // Opcode carried in bits [18:17] of the control word
    typedef enum logic [1:0] {
        END   = 2'b00,
        RSVD  = 2'b01,
        START = 2'b10,
        STOP  = 2'b11
    } comm_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEP_WAIT = 3'd1,
        DRAIN    = 3'd2,
        POST     = 3'd3,
        HALTED   = 3'd4
    } comm_state_t;

    // Control word as decoded by the fetch unit
    typedef struct packed {
        comm_op_t    op;
        logic        dep;
        logic [15:0] payload;
    } comm_word_t;

    // Primary opcode of instructions routed to this unit
    localparam logic [5:0] COMM_OPCODE = 6'b111111;

    // True for words that must stall fetch in the cycle they are presented
    function automatic logic op_stalls(comm_word_t w);
        return ((w.op == START) && w.dep) || (w.op == STOP) || (w.op == END);
    endfunction

endpackage

// File: rtl/comm_unit_if.sv
// Bundle between the fetch unit (master) and the communication unit (slave),
// including the inter-process event flag signals.
interface comm_unit_if #(
    parameter int SIG_W = 16
) ();
    logic              communication_enable_in;
    logic [18:0]       communication_signal_in;
    logic [SIG_W-1:0]  event_flags_in;
    logic              wait_for_next_out;
    logic [SIG_W-1:0]  event_ack_out;
    logic [SIG_W-1:0]  event_flags_out;
    logic              event_valid_out;
    logic              finished_out;
    logic              error_out;

    modport master (
        output communication_enable_in,
        output communication_signal_in,
        output event_flags_in,
        input  wait_for_next_out,
        input  event_ack_out,
        input  event_flags_out,
        input  event_valid_out,
        input  finished_out,
        input  error_out
    );

    modport slave (
        input  communication_enable_in,
        input  communication_signal_in,
        input  event_flags_in,
        output wait_for_next_out,
        output event_ack_out,
        output event_flags_out,
        output event_valid_out,
        output finished_out,
        output error_out
    );
endinterface

// File: rtl/comm_unit_drain_counter.sv
// Down-counter that times the pipeline drain before a publish. Loaded with
// DRAIN_CYCLES-1 on a stop, decremented while draining, saturates at zero.
module drain_counter #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DRAIN_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload wins over decrement; never decrement past zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/comm_unit.sv
// Communication unit: executes start/stop/end control words from fetch,
// handling dependency waits, drain-then-publish of completion signals and
// the terminal halt, and stalls fetch while any of these is in progress.
module comm_unit
    import COMM_PKG::*;
#(
    parameter int SIG_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    comm_unit_if.slave  bus
);
    comm_word_t       word;
    comm_state_t      state_q, state_d;
    logic [SIG_W-1:0] mask_q, mask_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] ack_q, ack_d;
    logic [SIG_W-1:0] flags_q, flags_d;
    logic             error_q, error_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign word = comm_word_t'(bus.communication_signal_in);

    drain_counter #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_drain (
        .clock  (clock),
        .reset  (reset),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    // Next-state and datapath updates; commands are only taken in IDLE
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        sig_d    = sig_q;
        ack_d    = '0;
        flags_d  = flags_q;
        error_d  = error_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.communication_enable_in) begin
                    case (word.op)
                        START: begin
                            if (word.dep) begin
                                mask_d  = word.payload[SIG_W-1:0];
                                state_d = DEP_WAIT;
                            end
                        end
                        STOP: begin
                            sig_d    = word.payload[SIG_W-1:0];
                            cnt_load = 1'b1;
                            state_d  = DRAIN;
                        end
                        END: begin
                            state_d = HALTED;
                        end
                        default: begin
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            DEP_WAIT: begin
                // Checked from the cycle after entry; no same-cycle bypass
                if ((bus.event_flags_in & mask_q) == mask_q) begin
                    ack_d   = mask_q;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    state_d = POST;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            POST: begin
                flags_d = sig_q;
                state_d = IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sig_q   <= '0;
            ack_q   <= '0;
            flags_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sig_q   <= sig_d;
            ack_q   <= ack_d;
            flags_q <= flags_d;
            error_q <= error_d;
        end
    end

    // The IDLE term lets fetch stall in the cycle it presents the word;
    // gating with reset drops the stall as soon as reset asserts.
    assign bus.wait_for_next_out = reset &
        ((state_q != IDLE) ||
         (bus.communication_enable_in && op_stalls(word)));

    assign bus.event_ack_out   = ack_q;
    assign bus.event_flags_out = flags_q;
    assign bus.event_valid_out = (state_q == POST);
    assign bus.finished_out    = (state_q == HALTED);
    assign bus.error_out       = error_q;

endmodule

// File: tb/tb_comm_unit.sv
// Directed testbench for comm_unit.
module tb_comm_unit;
    import COMM_PKG::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    comm_unit_if #(.SIG_W(16)) bus ();

    comm_unit #(
        .SIG_W        (16),
        .DRAIN_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge, then let comb logic settle
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic present(input logic en, input logic [1:0] op, input logic dep,
                           input logic [15:0] payload);
        bus.communication_enable_in = en;
        bus.communication_signal_in = {op, dep, payload};
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.event_flags_in = 16'h0000;
        present(1'b1, 2'b11, 1'b0, 16'h1234);
        cyc(); cyc();
        checks++;
        if ({bus.wait_for_next_out, bus.event_ack_out, bus.event_flags_out,
             bus.event_valid_out, bus.finished_out, bus.error_out} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b ack=%h flags=%h valid=%b fin=%b err=%b want all 0",
                     bus.wait_for_next_out, bus.event_ack_out, bus.event_flags_out,
                     bus.event_valid_out, bus.finished_out, bus.error_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.wait_for_next_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_stall: got %b want 1", bus.wait_for_next_out);
        end
        cyc();
        present(1'b0, 2'b00, 1'b0, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.wait_for_next_out !== 1'b1 || bus.event_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_stop_drain cycle %0d: got stall=%b valid=%b want 1 0",
                         i, bus.wait_for_next_out, bus.event_valid_out);
            end
            cyc();
        end
        checks++;
        if (bus.event_valid_out !== 1'b1 || bus.event_flags_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_stop_post: got valid=%b flags=%h want 1 0000",
                     bus.event_valid_out, bus.event_flags_out);
        end
        cyc();
        checks++;
        if (bus.wait_for_next_out !== 1'b0 || bus.event_flags_out !== 16'h1234) begin
            errors++;
            $display("FAIL reset_stop_done: got stall=%b flags=%h want 0 1234",
                     bus.wait_for_next_out, bus.event_flags_out);
        end
    endtask

    task automatic test_independent_start();
        present(1'b1, 2'b10, 1'b0, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.wait_for_next_out !== 1'b0 || bus.event_ack_out !== 16'h0000) begin
                errors++;
                $display("FAIL indep_start cycle %0d: got stall=%b ack=%h want 0 0000",
                         i, bus.wait_for_next_out, bus.event_ack_out);
            end
            cyc();
        end
        present(1'b0, 2'b00, 1'b0, 16'h0000);
    endtask

    task automatic test_dependent_start();
        bus.event_flags_in = 16'h21E4;
        present(1'b1, 2'b10, 1'b1, 16'h21E6);
        checks++;
        if (bus.wait_for_next_out !== 1'b1) begin
            errors++;
            $display("FAIL dep_stall_comb: got %b want 1", bus.wait_for_next_out);
        end
        cyc();
        present(1'b0, 2'b00, 1'b0, 16'h0000);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (bus.wait_for_next_out !== 1'b1 || bus.event_ack_out !== 16'h0000) begin
                errors++;
                $display("FAIL dep_wait cycle %0d: got stall=%b ack=%h want 1 0000",
                         i, bus.wait_for_next_out, bus.event_ack_out);
            end
            if (i < 5) cyc();
        end
        bus.event_flags_in = 16'h21E6;
        cyc();
        checks++;
        if (bus.event_ack_out !== 16'h21E6 || bus.wait_for_next_out !== 1'b0) begin
            errors++;
            $display("FAIL dep_release: got ack=%h stall=%b want 21E6 0",
                     bus.event_ack_out, bus.wait_for_next_out);
        end
        cyc();
        checks++;
        if (bus.event_ack_out !== 16'h0000 || bus.wait_for_next_out !== 1'b0) begin
            errors++;
            $display("FAIL dep_ack_pulse: got ack=%h stall=%b want 0000 0",
                     bus.event_ack_out, bus.wait_for_next_out);
        end
        bus.event_flags_in = 16'h0000;
    endtask

    task automatic test_zero_mask();
        present(1'b1, 2'b10, 1'b1, 16'h0000);
        cyc();
        present(1'b0, 2'b00, 1'b0, 16'h0000);
        checks++;
        if (bus.wait_for_next_out !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_wait: got stall=%b want 1", bus.wait_for_next_out);
        end
        cyc();
        checks++;
        if (bus.wait_for_next_out !== 1'b0 || bus.event_ack_out !== 16'h0000) begin
            errors++;
            $display("FAIL zero_mask_release: got stall=%b ack=%h want 0 0000",
                     bus.wait_for_next_out, bus.event_ack_out);
        end
    endtask

    task automatic test_stop();
        int valid_count;
        valid_count = 0;
        present(1'b1, 2'b11, 1'b0, 16'hA5A5);
        checks++;
        if (bus.wait_for_next_out !== 1'b1) begin
            errors++;
            $display("FAIL stop_stall_comb: got %b want 1", bus.wait_for_next_out);
        end
        cyc();
        present(1'b0, 2'b00, 1'b0, 16'h0000);
        for (int i = 1; i <= 6; i++) begin
            // A second stop offered mid-drain must be ignored
            if (i == 2) present(1'b1, 2'b11, 1'b0, 16'h5A5A);
            if (i == 3) present(1'b0, 2'b00, 1'b0, 16'h0000);
            if (bus.event_valid_out === 1'b1) valid_count++;
            checks++;
            if (bus.wait_for_next_out !== 1'b1 || bus.event_valid_out !== (i == 5)) begin
                errors++;
                $display("FAIL stop_timing cycle N+%0d: got stall=%b valid=%b want 1 %b",
                         i, bus.wait_for_next_out, bus.event_valid_out, (i == 5));
            end
            if (i == 5) begin
                checks++;
                if (bus.event_flags_out !== 16'h1234) begin
                    errors++;
                    $display("FAIL stop_flags_hold: got %h want 1234", bus.event_flags_out);
                end
            end
            if (i == 5) begin
                cyc();
                break;
            end
            cyc();
        end
        for (int i = 6; i <= 14; i++) begin
            if (bus.event_valid_out === 1'b1) valid_count++;
            cyc();
        end
        checks++;
        if (bus.wait_for_next_out !== 1'b0 || bus.event_flags_out !== 16'hA5A5) begin
            errors++;
            $display("FAIL stop_done: got stall=%b flags=%h want 0 A5A5",
                     bus.wait_for_next_out, bus.event_flags_out);
        end
        checks++;
        if (valid_count !== 1) begin
            errors++;
            $display("FAIL stop_single_publish: got %0d publishes want 1", valid_count);
        end
    endtask

    task automatic test_reserved();
        present(1'b1, 2'b01, 1'b0, 16'h0F0F);
        checks++;
        if (bus.wait_for_next_out !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_no_stall: got %b want 0", bus.wait_for_next_out);
        end
        cyc();
        present(1'b0, 2'b00, 1'b0, 16'h0000);
        cyc();
        checks++;
        if (bus.error_out !== 1'b1 || bus.wait_for_next_out !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_sticky: got err=%b stall=%b want 1 0",
                     bus.error_out, bus.wait_for_next_out);
        end
    endtask

    task automatic test_mid_reset();
        present(1'b1, 2'b11, 1'b0, 16'hBEEF);
        cyc();
        present(1'b0, 2'b00, 1'b0, 16'h0000);
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.wait_for_next_out !== 1'b0 || bus.error_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got stall=%b err=%b want 0 0",
                     bus.wait_for_next_out, bus.error_out);
        end
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.event_valid_out !== 1'b0 || bus.wait_for_next_out !== 1'b0) begin
                errors++;
                $display("FAIL midreset_lost_publish cycle %0d: got valid=%b stall=%b want 0 0",
                         i, bus.event_valid_out, bus.wait_for_next_out);
            end
            cyc();
        end
        checks++;
        if (bus.event_flags_out !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_flags: got %h want 0000", bus.event_flags_out);
        end
    endtask

    task automatic test_end();
        present(1'b1, 2'b00, 1'b0, 16'h0000);
        checks++;
        if (bus.wait_for_next_out !== 1'b1) begin
            errors++;
            $display("FAIL end_stall_comb: got %b want 1", bus.wait_for_next_out);
        end
        cyc();
        bus.event_flags_in = 16'hFFFF;
        present(1'b1, 2'b10, 1'b1, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.wait_for_next_out !== 1'b1 || bus.finished_out !== 1'b1 ||
                bus.event_ack_out !== 16'h0000) begin
                errors++;
                $display("FAIL end_halted cycle %0d: got stall=%b fin=%b ack=%h want 1 1 0000",
                         i, bus.wait_for_next_out, bus.finished_out, bus.event_ack_out);
            end
            cyc();
        end
        present(1'b0, 2'b00, 1'b0, 16'h0000);
        bus.event_flags_in = 16'h0000;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.wait_for_next_out !== 1'b0 || bus.finished_out !== 1'b0) begin
            errors++;
            $display("FAIL end_reset_clear: got stall=%b fin=%b want 0 0",
                     bus.wait_for_next_out, bus.finished_out);
        end
        cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (bus.finished_out !== 1'b0) begin
            errors++;
            $display("FAIL end_after_reset: got fin=%b want 0", bus.finished_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.communication_enable_in = 1'b0;
        bus.communication_signal_in = '0;
        bus.event_flags_in = '0;
        #3;
        test_reset();
        test_independent_start();
        test_dependent_start();
        test_zero_mask();
        test_stop();
        test_reserved();
        test_mid_reset();
        test_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
